// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter: FSM states, requester
// encoding, default memory depth and the address bounds check.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    RESUME = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH  = 1'b0,
    LOADER = 1'b1
  } owner_t;

  localparam int IMEM_DEPTH_DEFAULT = 191;

  // Widened compare so a depth equal to 2^ADDR_W does not wrap.
  function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Two-way grant selector between fetch and loader. Build with IMEM_ARB_RR_EN
// defined for round-robin on contention; otherwise the loader has fixed priority.
module imem_arb_pick
  import imem_arb_pkg::*;
(
`ifdef IMEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic fetch_elig,
  input  logic ld_elig,
  output logic fetch_win,
  output logic ld_win
);

`ifdef IMEM_ARB_RR_EN
  owner_t last_winner_reg;

  always_comb begin
    fetch_win = 1'b0;
    ld_win    = 1'b0;
    if (fetch_elig && ld_elig) begin
      if (last_winner_reg == LOADER) begin
        fetch_win = 1'b1;
      end else begin
        ld_win = 1'b1;
      end
    end else begin
      fetch_win = fetch_elig;
      ld_win    = ld_elig;
    end
  end

  // Reset to LOADER so the first contended cycle goes to fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner_reg <= LOADER;
    end else if (fetch_elig && ld_elig) begin
      last_winner_reg <= (last_winner_reg == LOADER) ? FETCH : LOADER;
    end
  end
`else
  assign ld_win    = ld_elig;
  assign fetch_win = fetch_elig && !ld_elig;
`endif

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port synchronous-read instruction memory between CPU fetch
// and the program loader, with a load-mode lock. Optional macro: IMEM_ARB_RR_EN.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_err,
  input  logic              ld_lock,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt,
  output logic              ld_err,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] wr_count,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_instr_in,
  input  logic [DATA_W-1:0] mem_instr_out
);

  arb_state_t        state_reg;
  logic              cpu_hold_reg;
  logic              fetch_valid_reg;
  logic              fetch_err_reg;
  logic [ADDR_W-1:0] wr_count_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_instr_in_reg;

  logic fetch_elig;
  logic ld_elig;
  logic fetch_win;
  logic ld_win;
  logic fetch_in_range;
  logic ld_in_range;
  logic rd_ok;
  logic wr_ok;
  logic enter_load;

  // Fetch only in RUN; loader in RUN or LOAD; nobody during RESUME or reset.
  assign fetch_elig = fetch_req && !rst && (state_reg == RUN);
  assign ld_elig    = ld_req && !rst && (state_reg != RESUME);

  imem_arb_pick u_pick (
`ifdef IMEM_ARB_RR_EN
    .clk        (clk),
    .rst        (rst),
`endif
    .fetch_elig (fetch_elig),
    .ld_elig    (ld_elig),
    .fetch_win  (fetch_win),
    .ld_win     (ld_win)
  );

  assign fetch_in_range = addr_ok(64'(fetch_addr), 64'(MEM_DEPTH));
  assign ld_in_range    = addr_ok(64'(ld_addr), 64'(MEM_DEPTH));
  assign rd_ok          = fetch_win && fetch_in_range;
  assign wr_ok          = ld_win && ld_in_range;
  assign enter_load     = ld_lock && !rst && (state_reg != LOAD);

  assign fetch_gnt = fetch_win;
  assign ld_gnt    = ld_win;
  assign ld_err    = ld_win && !ld_in_range;

  // Out-of-range grants leave the memory port untouched.
  always_comb begin
    mem_write_en = wr_ok;
    mem_addr     = mem_addr_reg;
    mem_instr_in = mem_instr_in_reg;
    if (wr_ok) begin
      mem_addr     = ld_addr;
      mem_instr_in = ld_data;
    end else if (rd_ok) begin
      mem_addr = fetch_addr;
    end
  end

  // A read granted just before reset must not surface during the reset cycle.
  assign fetch_valid = fetch_valid_reg && !rst;
  assign fetch_err   = fetch_err_reg && !rst;
  assign fetch_instr = (fetch_valid && !fetch_err_reg) ? mem_instr_out : '0;
  assign cpu_hold    = cpu_hold_reg;
  assign wr_count    = wr_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RUN;
      cpu_hold_reg     <= 1'b0;
      fetch_valid_reg  <= 1'b0;
      fetch_err_reg    <= 1'b0;
      wr_count_reg     <= '0;
      mem_addr_reg     <= '0;
      mem_instr_in_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (ld_lock) begin
            state_reg    <= LOAD;
            cpu_hold_reg <= 1'b1;
          end
        end
        LOAD: begin
          if (!ld_lock) begin
            state_reg <= RESUME;
          end
        end
        RESUME: begin
          if (ld_lock) begin
            state_reg <= LOAD;
          end else begin
            state_reg    <= RUN;
            cpu_hold_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= RUN;
          cpu_hold_reg <= 1'b0;
        end
      endcase

      if (enter_load) begin
        wr_count_reg <= '0;
      end else if (wr_ok && (wr_count_reg != {ADDR_W{1'b1}})) begin
        wr_count_reg <= wr_count_reg + 1'b1;
      end

      fetch_valid_reg  <= fetch_win;
      fetch_err_reg    <= fetch_win && !fetch_in_range;
      mem_addr_reg     <= mem_addr;
      mem_instr_in_reg <= mem_instr_in;
    end
  end

endmodule
